// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between two requesters.
// One operation is in flight at a time, and the result is held until the owner consumes it.
module alu_share_ctrl #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2:0]           req0_op,
  input  logic [DATAWIDTH-1:0] req0_a,
  input  logic [DATAWIDTH-1:0] req0_b,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2:0]           req1_op,
  input  logic [DATAWIDTH-1:0] req1_a,
  input  logic [DATAWIDTH-1:0] req1_b,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic [2:0]           rsp_flags,
  output logic                 busy
);

  // valid/ready: a transfer happens on a rising edge where both valid and ready are high.
  // A requester holds valid and its payload until ready; dropping valid withdraws the request.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t                 state;
  logic                   last_grant;
  logic                   owner;
  logic [2:0]             op_q;
  logic [DATAWIDTH-1:0]   a_q;
  logic [DATAWIDTH-1:0]   b_q;
  logic                   grant0;
  logic                   grant1;
  logic [DATAWIDTH:0]     sum_ext;
  logic [DATAWIDTH:0]     diff_ext;
  logic [DATAWIDTH-1:0]   alu_res;
  logic                   alu_c;
  logic                   alu_v;
  logic                   owner_rsp_ready;

  // Under contention, the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready      = grant0;
  assign req1_ready      = grant1;
  assign busy            = (state != IDLE);
  assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    diff_ext = {1'b0, a_q} - {1'b0, b_q};
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (op_q)
      3'b000: begin
        alu_res = sum_ext[DATAWIDTH-1:0];
        alu_c   = sum_ext[DATAWIDTH];
        alu_v   = (a_q[DATAWIDTH-1] == b_q[DATAWIDTH-1]) &&
                  (sum_ext[DATAWIDTH-1] != a_q[DATAWIDTH-1]);
      end
      3'b001: begin
        alu_res = diff_ext[DATAWIDTH-1:0];
        alu_c   = diff_ext[DATAWIDTH];
        alu_v   = (a_q[DATAWIDTH-1] != b_q[DATAWIDTH-1]) &&
                  (diff_ext[DATAWIDTH-1] != a_q[DATAWIDTH-1]);
      end
      3'b010: alu_res = ~a_q;
      3'b011: alu_res = a_q & b_q;
      3'b100: alu_res = a_q | b_q;
      3'b101: alu_res = a_q ^ b_q;
      3'b110: alu_res = {{(DATAWIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = {{(DATAWIDTH-1){1'b0}}, (a_q == b_q)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
      rsp_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_q       <= grant1 ? req1_op : req0_op;
            a_q        <= grant1 ? req1_a  : req0_a;
            b_q        <= grant1 ? req1_b  : req0_b;
            owner      <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_res;
          rsp_flags  <= {alu_c, alu_v, (alu_res == '0)};
          rsp0_valid <= ~owner;
          rsp1_valid <= owner;
          state      <= RESP;
        end
        RESP: begin
          // The non-owner's rsp_ready is ignored.
          if (owner_rsp_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a transaction-level model checked every cycle,
// directed cases with literal results, then randomized traffic.
module tb_alu_share_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [2:0]   rsp_flags;
  logic         busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  alu_share_ctrl #(.DATAWIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic; flags packed as carry*4 + overflow*2 + zero.
  function automatic void alu_model(input int op, input int a, input int b,
                                    output int res, output int fl);
    int m, sa, sb, c, v;
    m = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    c = 0;
    v = 0;
    case (op)
      0: begin res = (a + b) % m; c = (a + b >= m); v = (sa + sb < -m / 2) || (sa + sb >= m / 2); end
      1: begin res = (a - b + m) % m; c = (a < b); v = (sa - sb < -m / 2) || (sa - sb >= m / 2); end
      2: res = (m - 1) - a;
      3: res = a & b;
      4: res = a | b;
      5: res = a ^ b;
      6: res = (sa < sb) ? 1 : 0;
      default: res = (a == b) ? 1 : 0;
    endcase
    fl = c * 4 + v * 2 + ((res == 0) ? 1 : 0);
  endfunction

  // Transaction model: in flight or not, cycles since accept, owner, held result.
  bit m_busy = 1'b0;
  int m_owner = 0, m_age = 0, m_last = 1, m_data = 0, m_flags = 0, m_res = 0, m_fl = 0;
  int cyc = 0;
  int grant_owner_q[$];
  int grant_cyc_q[$];

  always @(negedge clk) begin
    int e_r0, e_r1, e_v0, e_v1, own_rdy;
    if (chk_en) begin
      cyc++;
      e_r0 = (!m_busy && req0_valid && (!req1_valid || m_last == 1)) ? 1 : 0;
      e_r1 = (!m_busy && req1_valid && (!req0_valid || m_last == 0)) ? 1 : 0;
      e_v0 = (m_busy && m_age >= 1 && m_owner == 0) ? 1 : 0;
      e_v1 = (m_busy && m_age >= 1 && m_owner == 1) ? 1 : 0;
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("rsp0_valid", rsp0_valid, e_v0);
      chk("rsp1_valid", rsp1_valid, e_v1);
      chk("busy", busy, m_busy ? 1 : 0);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_flags", rsp_flags, m_flags);
      own_rdy = (m_owner == 0) ? rsp0_ready : rsp1_ready;
      if (rst) begin
        m_busy = 1'b0; m_age = 0; m_last = 1; m_data = 0; m_flags = 0;
      end else if (!m_busy) begin
        if (e_r0 == 1 || e_r1 == 1) begin
          m_owner = (e_r1 == 1) ? 1 : 0;
          if (m_owner == 0) alu_model(req0_op, req0_a, req0_b, m_res, m_fl);
          else              alu_model(req1_op, req1_a, req1_b, m_res, m_fl);
          m_busy = 1'b1;
          m_age = 0;
          m_last = m_owner;
          grant_owner_q.push_back(m_owner);
          grant_cyc_q.push_back(cyc);
        end
      end else begin
        if (m_age == 0) begin
          m_data = m_res;
          m_flags = m_fl;
        end else if (own_rdy == 1) begin
          m_busy = 1'b0;
        end
        m_age++;
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Issue one command with its response ready high, and pin latency and result to literals.
  task automatic do_op(input int who, input int op, input int a, input int b,
                       input int ed, input int ef, input string nm);
    bit got;
    int v;
    got = 1'b0;
    @(posedge clk); #1;
    if (who == 0) begin req0_op = 3'(op); req0_a = W'(a); req0_b = W'(b); req0_valid = 1'b1; end
    else          begin req1_op = 3'(op); req1_a = W'(a); req1_b = W'(b); req1_valid = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if ((who == 0 && req0_ready) || (who == 1 && req1_ready)) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk({nm, " accepted"}, got, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    v = (who == 0) ? rsp0_valid : rsp1_valid;
    chk({nm, " valid during exec"}, v, 0);
    @(negedge clk);
    v = (who == 0) ? rsp0_valid : rsp1_valid;
    chk({nm, " valid after 2 cycles"}, v, 1);
    chk({nm, " data"}, rsp_data, ed);
    chk({nm, " flags"}, rsp_flags, ef);
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] edges [4];
    edges[0] = '0; edges[1] = {1'b0, {(W-1){1'b1}}};
    edges[2] = {1'b1, {(W-1){1'b0}}}; edges[3] = '1;
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    bit hs0, hs1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset rsp_data", rsp_data, 0);

    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    do_op(0, 0, 'h7F, 'h01, 'h80, 3'b010, "add 7f+01");
    do_op(1, 1, 'h05, 'h06, 'hFF, 3'b100, "sub 05-06");
    do_op(1, 7, 'h3C, 'h3C, 'h01, 3'b000, "equ 3c");
    do_op(0, 6, 'h80, 'h01, 'h01, 3'b000, "comp 80<01");
    do_op(0, 2, 'hFF, 'h00, 'h00, 3'b001, "not ff");
    do_op(1, 0, 'hFF, 'h01, 'h00, 3'b101, "add ff+01");
    do_op(0, 1, 'h80, 'h01, 'h7F, 3'b010, "sub 80-01");

    // Contention from reset: strict alternation, one grant every 3 cycles.
    pulse_reset();
    grant_owner_q.delete();
    grant_cyc_q.delete();
    req0_op = 3'd0; req0_a = 8'h11; req0_b = 8'h22; req0_valid = 1'b1;
    req1_op = 3'd0; req1_a = 8'h33; req1_b = 8'h44; req1_valid = 1'b1;
    repeat (13) @(posedge clk);
    #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("contention grant count", (grant_owner_q.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++)
      chk("contention grant owner", (i < grant_owner_q.size()) ? grant_owner_q[i] : -1, i % 2);
    for (int i = 1; i < 4; i++)
      chk("contention grant spacing",
          (i < grant_cyc_q.size()) ? grant_cyc_q[i] - grant_cyc_q[i-1] : -1, 3);

    // Backpressure on requester 0 while requester 1 keeps asking.
    pulse_reset();
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    req0_op = 3'd5; req0_a = 8'hF0; req0_b = 8'hFF; req0_valid = 1'b1;
    req1_op = 3'd0; req1_a = 8'h01; req1_b = 8'h02; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp req0 granted", req0_ready, 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp rsp0_valid held", rsp0_valid, 1);
      chk("bp data held", rsp_data, 'h0F);
      chk("bp flags held", rsp_flags, 3'b000);
      chk("bp req1 blocked", req1_ready, 0);
    end
    @(posedge clk); #1 rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp req1 blocked at consume", req1_ready, 0);
    @(negedge clk);
    chk("bp rsp0 dropped", rsp0_valid, 0);
    chk("bp req1 granted after consume", req1_ready, 1);
    @(posedge clk); #1 req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Reset while a response is pending.
    pulse_reset();
    rsp0_ready = 1'b0;
    req0_op = 3'd0; req0_a = 8'h10; req0_b = 8'h20; req0_valid = 1'b1;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst-resp pending valid", rsp0_valid, 1);
    chk("rst-resp pending data", rsp_data, 'h30);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst-resp rsp0_valid", rsp0_valid, 0);
    chk("rst-resp data", rsp_data, 0);
    chk("rst-resp flags", rsp_flags, 0);
    chk("rst-resp busy", busy, 0);
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("rst-resp first grant req0", req0_ready, 1);
    chk("rst-resp first grant not req1", req1_ready, 0);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Randomized traffic with backpressure, withdrawals and occasional resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = 3'($urandom_range(0, 7)); req0_a = rnd_operand(); req0_b = rnd_operand();
      end else if ($urandom_range(0, 19) == 0) req0_valid = 1'b0;
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = 3'($urandom_range(0, 7)); req1_a = rnd_operand(); req1_b = rnd_operand();
      end else if ($urandom_range(0, 19) == 0) req1_valid = 1'b0;
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drained busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
Arbitration and sequencing controller that shares one DATAWIDTH-bit ALU between two requesters. It uses the team's 3-bit ALU op encoding: ADD, SUB, NOT, AND, OR, XOR, COMP, EQU. Each requester issues a command over a valid/ready channel and receives a registered result plus flags over a valid/ready response channel. Arbitration is round-robin and only one operation is in flight at a time. The block sits between the instruction/test front-ends and the ALU datapath.

Parameters:
DATAWIDTH, 8, operand and result width (minimum 2)

Ports:
clk  in  1  clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted (combinational)
req0_op  in  3  requester 0 opcode
req0_a  in  DATAWIDTH  requester 0 operand A
req0_b  in  DATAWIDTH  requester 0 operand B
rsp0_valid  out  1  requester 0 result valid
rsp0_ready  in  1  requester 0 result consumed
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
rsp1_valid, rsp1_ready  same as requester 0, for requester 1
rsp_data  out  DATAWIDTH  result, shared by both response channels
rsp_flags  out  3  {carry, overflow, zero}, shared by both response channels
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first contention).
  - rsp0_valid=rsp1_valid=0, rsp_data=0, rsp_flags=0, busy=0.
  - Internal operand, op and owner registers cleared.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Granted reqN_ready=1 in the same cycle. Only one ready is ever high, and readies are 0 in every other state.
  - On the handshake: latch op, a, b and owner; set last_grant=owner; go to EXEC.
- EXEC (1 cycle): compute the result from the latched operands and register rsp_data and rsp_flags. Go to RESP.
- RESP:
  - rspN_valid=1 for the owner only. rsp_data and rsp_flags stay stable until the handshake.
  - When rspN_ready is high: rspN_valid drops on the next edge and the state returns to IDLE.
  - There is no bypass: a new grant happens no earlier than the cycle after return to IDLE.
- Latency and throughput:
  - Command accept to rsp_valid = 2 cycles.
  - Minimum 3 cycles per operation with rsp_ready held high.
- Op results, all arithmetic modulo 2^DATAWIDTH:
  - 000 ADD = a+b. 001 SUB = a-b. 010 NOT = ~a. 011 AND = a&b. 100 OR = a|b. 101 XOR = a^b.
  - 110 COMP = 1 if signed a < signed b, else 0 (zero-extended).
  - 111 EQU = 1 if a==b, else 0.
- Flags:
  - carry: ADD = carry out of the MSB. SUB = borrow (unsigned a<b). All other ops = 0.
  - overflow: ADD = a,b same sign and result sign differs. SUB = a,b signs differ and result sign differs from a. All other ops = 0.
  - zero = (result==0), for every op.
- Fairness: with both requesters continuously valid, grants strictly alternate. No requester waits more than one other operation.
- Response backpressure: requests arriving while rsp_ready is held low are not accepted. Their req_valid must stay asserted; dropping it withdraws the request without side effects.
- Owner's rsp_valid high with the other requester's rsp_ready high has no effect.
- Reset mid-operation (EXEC or RESP): the transaction is discarded with no response. Outputs return to reset values on the next edge.

Test Plan:
1. Single ADD: req0 op=000 a=8'h7F b=8'h01, rsp0_ready=1 -> req0_ready in accept cycle, rsp0_valid 2 cycles later, rsp_data=8'h80, flags={0,1,0}.
2. SUB with borrow and EQU: req1 SUB a=8'h05 b=8'h06 -> rsp1 data=8'hFF, flags={1,0,0}. Then EQU a=b=8'h3C -> data=8'h01, flags={0,0,0}.
3. Contention from reset: both valid, back-to-back ADDs with rsp_ready=1 -> grants 0,1,0,1 alternate, a grant every 3 cycles, each result on the correct rspN_valid only.
4. Backpressure: rsp0_ready=0 for 5 cycles after XOR a=8'hF0 b=8'hFF -> rsp0_valid, data=8'h0F and flags stay stable. req1 stays valid but is not granted (req1_ready=0) until one cycle after rsp0 is consumed.
5. COMP and NOT: COMP a=8'h80 b=8'h01 -> data=8'h01. NOT a=8'hFF -> data=8'h00, zero=1.
6. Reset in RESP: rst asserted while rsp0_valid=1 -> next cycle all outputs are 0 and busy=0. A subsequent contention is granted to requester 0.
